// File: rtl/wb_slave_pipeline_burst_pkg.sv
// Shared encodings for the pipelined Wishbone burst slave: CTI codes,
// response classes and grant FSM states.
package wb_slave_pipeline_burst_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_ACK  = 2'b01,
        RSP_RTY  = 2'b10,
        RSP_ERR  = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        GNT_IDLE    = 2'b00,
        GNT_GRANT   = 2'b01,
        GNT_BUSY    = 2'b10,
        GNT_RELEASE = 2'b11
    } gnt_state_e;

endpackage

// File: rtl/wb_slave_pipeline_burst_rsp_delay_line.sv
// Fixed-latency response shift register carrying {valid, class, data};
// flush_i drops every in-flight entry on the next edge.
module wb_rsp_delay_line
    import wb_slave_pipeline_burst_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    input  logic [1:0]    in_cls_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic [1:0]    out_cls_o,
    output logic [DW-1:0] out_data_o
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [1:0]         cls_q  [LATENCY];
    logic [1:0]         cls_d  [LATENCY];
    logic [DW-1:0]      data_q [LATENCY];
    logic [DW-1:0]      data_d [LATENCY];

    // shift every stage by one, clearing valids on flush
    always_comb begin
        valid_d[0] = in_valid_i & ~flush_i;
        cls_d[0]   = in_cls_i;
        data_d[0]  = in_data_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1] & ~flush_i;
            cls_d[i]   = cls_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                cls_q[i]  <= RSP_NONE;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                cls_q[i]  <= cls_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_cls_o   = valid_q[LATENCY-1] ? cls_q[LATENCY-1] : RSP_NONE;
    assign out_data_o  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;

endmodule

// File: rtl/wb_slave_pipeline_burst.sv
// Wishbone B4 pipelined slave with burst address checking, fixed response
// latency, outstanding/periodic stall, RTY/ERR injection and a bus grant FSM.
module wb_slave_pipeline_burst
    import wb_slave_pipeline_burst_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH    = 32,
    parameter int unsigned BUS_ADDRESS_WIDTH = 32,
    parameter int unsigned GRANULARITY       = 8,
    parameter int unsigned ADDR_LSB          = 2,
    parameter int unsigned MEM_AW            = 6,
    parameter int unsigned ACK_LATENCY       = 2,
    parameter int unsigned MAX_OUTSTANDING   = 4,
    parameter int unsigned STALL_PERIOD      = 0,
    parameter int unsigned GNT_DELAY         = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  CYC_I,
    input  logic                                  STB_I,
    input  logic                                  WE_I,
    input  logic [BUS_ADDRESS_WIDTH-1:0]          ADR_I,
    input  logic [BUS_DATA_WIDTH-1:0]             DAT_I,
    input  logic [BUS_DATA_WIDTH/GRANULARITY-1:0] SEL_I,
    input  logic [2:0]                            CTI_I,
    input  logic                                  inject_rty_i,
    output logic                                  gnt_wb_o,
    output logic [BUS_DATA_WIDTH-1:0]             DAT_O,
    output logic                                  ACK_O,
    output logic                                  RTY_O,
    output logic                                  ERR_O,
    output logic                                  STALL_O,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o
);

    localparam int unsigned SW    = BUS_DATA_WIDTH / GRANULARITY;
    localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam int unsigned GCW   = $clog2(GNT_DELAY + 2);
    localparam int unsigned SCW   = $clog2(STALL_PERIOD + 2);
    localparam logic [OW-1:0]  OS_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [GCW-1:0] GD_LAST = GCW'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
    localparam logic [SCW-1:0] SP_LIM  = SCW'(STALL_PERIOD);

    gnt_state_e                state_q, state_d;
    logic [GCW-1:0]            gcnt_q, gcnt_d;
    logic [OW-1:0]             os_q, os_d;
    logic [SCW-1:0]            scnt_q, scnt_d;
    logic                      in_burst_q, in_burst_d;
    logic [MEM_AW-1:0]         last_q, last_d;
    logic [DEPTH-1:0]          mem_vld_q;
    logic [BUS_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                      gnt_active_s, accept_s, stall_pat_s, wr_en_s;
    logic                      rsp_valid_s;
    logic [1:0]                rsp_cls_s;
    logic [BUS_DATA_WIDTH-1:0] rsp_data_s, rd_data_s;
    logic [MEM_AW-1:0]         waddr_s, next_waddr_s;
    rsp_e                      cls_s;
    logic                      unused_adr_s;

    assign unused_adr_s = ^ADR_I[ADDR_LSB-1:0];

    // grant FSM: next state
    always_comb begin
        state_d = state_q;
        gcnt_d  = '0;
        case (state_q)
            GNT_IDLE: begin
                if (gcnt_q == GD_LAST) state_d = GNT_GRANT;
                else                   gcnt_d  = gcnt_q + 1'b1;
            end
            GNT_GRANT: begin
                if (CYC_I) state_d = GNT_BUSY;
                else       state_d = GNT_GRANT;
            end
            GNT_BUSY: begin
                if (!CYC_I) state_d = GNT_RELEASE;
                else        state_d = GNT_BUSY;
            end
            GNT_RELEASE: state_d = GNT_IDLE;
            default:     state_d = GNT_IDLE;
        endcase
    end

    assign gnt_active_s = (state_q == GNT_GRANT) || (state_q == GNT_BUSY);
    assign gnt_wb_o     = gnt_active_s;

    assign stall_pat_s = (STALL_PERIOD != 0) && (scnt_q == SP_LIM);
    assign STALL_O     = ((os_q == OS_MAX) && !rsp_valid_s) || stall_pat_s;
    assign accept_s    = CYC_I && STB_I && !STALL_O && gnt_active_s;

    assign waddr_s      = ADR_I[ADDR_LSB +: MEM_AW];
    assign next_waddr_s = last_q + 1'b1;

    // classify the request presented this cycle
    always_comb begin
        cls_s = RSP_ACK;
        if ((ADR_I >> (MEM_AW + ADDR_LSB)) != '0)          cls_s = RSP_ERR;
        else if (in_burst_q && (waddr_s != next_waddr_s))  cls_s = RSP_ERR;
        else if (inject_rty_i)                             cls_s = RSP_RTY;
        else                                               cls_s = RSP_ACK;
    end

    assign wr_en_s   = accept_s && WE_I && (cls_s == RSP_ACK);
    assign rd_data_s = (accept_s && !WE_I && (cls_s == RSP_ACK) && mem_vld_q[waddr_s])
                       ? mem_q[waddr_s] : '0;

    // burst tracking, outstanding count and stall-pattern counter
    always_comb begin
        in_burst_d = in_burst_q;
        last_d     = last_q;
        os_d       = os_q;
        scnt_d     = scnt_q;
        if (!CYC_I) begin
            in_burst_d = 1'b0;
            os_d       = '0;
            scnt_d     = '0;
        end else begin
            if (accept_s) begin
                in_burst_d = (CTI_I == CTI_INCR);
                last_d     = waddr_s;
            end else begin
                in_burst_d = in_burst_q;
            end
            if (accept_s && !rsp_valid_s)      os_d = os_q + 1'b1;
            else if (!accept_s && rsp_valid_s) os_d = os_q - 1'b1;
            else                               os_d = os_q;
            if (stall_pat_s)                               scnt_d = '0;
            else if (accept_s && (STALL_PERIOD != 0))      scnt_d = scnt_q + 1'b1;
            else                                           scnt_d = scnt_q;
        end
    end

    // control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= GNT_IDLE;
            gcnt_q     <= '0;
            os_q       <= '0;
            scnt_q     <= '0;
            in_burst_q <= 1'b0;
            last_q     <= '0;
            mem_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            os_q       <= os_d;
            scnt_q     <= scnt_d;
            in_burst_q <= in_burst_d;
            last_q     <= last_d;
            if (wr_en_s) mem_vld_q[waddr_s] <= 1'b1;
        end
    end

    // backing store: per-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < SW; l++) begin
            if (wr_en_s && SEL_I[l])
                mem_q[waddr_s][l*GRANULARITY +: GRANULARITY] <= DAT_I[l*GRANULARITY +: GRANULARITY];
        end
    end

    wb_rsp_delay_line #(
        .LATENCY (ACK_LATENCY),
        .DW      (BUS_DATA_WIDTH)
    ) u_rsp (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (~CYC_I),
        .in_valid_i  (accept_s),
        .in_cls_i    (cls_s),
        .in_data_i   (rd_data_s),
        .out_valid_o (rsp_valid_s),
        .out_cls_o   (rsp_cls_s),
        .out_data_o  (rsp_data_s)
    );

    assign ACK_O         = (rsp_cls_s == RSP_ACK);
    assign RTY_O         = (rsp_cls_s == RSP_RTY);
    assign ERR_O         = (rsp_cls_s == RSP_ERR);
    assign DAT_O         = rsp_data_s;
    assign outstanding_o = os_q;

endmodule

// File: doc/wb_slave_pipeline_burst.md
Name: wb_slave_pipeline_burst

Overview:
- Parametrised, synthesizable Wishbone B4 pipelined slave with burst support and programmable latency, stall and retry/error injection.
- Successor to the no-burst fake slave; serves as the bus-side partner of wb_master_interface in NIC benches and FPGA loopback builds.
- Also drives the I/O-arbiter grant toward the master.
- Backs accesses with an internal byte-lane-writable memory, so read-after-write is checkable.

Parameters:
- BUS_DATA_WIDTH, 32, data bus width.
- BUS_ADDRESS_WIDTH, 32, address bus width.
- GRANULARITY, 8, bits per SEL lane.
- ADDR_LSB, 2, byte-offset bits dropped to form the word address.
- MEM_AW, 6, log2 of memory depth in words.
- ACK_LATENCY, 2, cycles from accept to response (>=1).
- MAX_OUTSTANDING, 4, accepted-but-unanswered request limit (>=1).
- STALL_PERIOD, 0, insert 1 stall cycle after every N accepts (0 = off).
- GNT_DELAY, 1, idle cycles before gnt_wb_o rises (>=0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- CYC_I  in  1  bus cycle
- STB_I  in  1  strobe
- WE_I  in  1  write enable
- ADR_I  in  BUS_ADDRESS_WIDTH  byte address
- DAT_I  in  BUS_DATA_WIDTH  write data
- SEL_I  in  BUS_DATA_WIDTH/GRANULARITY  lane select
- CTI_I  in  3  cycle type (000 classic, 010 incrementing, 111 end)
- inject_rty_i  in  1  answer the request accepted this cycle with RTY
- gnt_wb_o  out  1  grant to master
- DAT_O  out  BUS_DATA_WIDTH  read data, valid with ACK_O
- ACK_O / RTY_O / ERR_O  out  1 each  termination
- STALL_O  out  1  pipeline stall
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count

Behaviour:
- Reset: all outputs 0, pipeline and memory-valid cleared, grant FSM in IDLE. Memory contents are not reset.
- Grant FSM:
  - IDLE: count GNT_DELAY cycles, then GRANT.
  - GRANT: gnt_wb_o=1; CYC_I rising -> BUSY.
  - BUSY: gnt_wb_o=1; CYC_I falling -> RELEASE.
  - RELEASE: gnt_wb_o=0 for 1 cycle -> IDLE.
  - GNT_DELAY=0: IDLE passes straight to GRANT on the next edge.
- Accept: cycle with CYC_I & STB_I & ~STALL_O & (state==BUSY or GRANT).
- STALL_O, combinational: (outstanding_o==MAX_OUTSTANDING and no response this cycle), or the stall-pattern cycle.
  - Stall pattern: accept counter reaches STALL_PERIOD, stalls exactly 1 cycle, then the counter clears.
- Per-accept classification, in priority order:
  1. ERR: address upper bits above MEM_AW+ADDR_LSB are non-zero.
  2. ERR: burst address check fails while in a 010 burst (word address != previous word address + 1, wrap at 2^MEM_AW).
  3. RTY: inject_rty_i=1.
  4. ACK otherwise.
- Writes commit to memory at accept, ACK class only, per SEL lane. Reads sample memory at accept.
- Ordering: a read accepted after a write to the same address returns the new data.
- Burst tracking:
  - CTI 010 sets in_burst and records the word address.
  - CTI 111 or 000 ends the burst after checking that beat.
  - First 010 beat is never address-checked.
- Response pipeline: ACK_LATENCY-stage shift register of {valid, class, data}.
  - Exactly one of ACK_O/RTY_O/ERR_O fires per accepted request, ACK_LATENCY cycles after accept, in order.
  - DAT_O=0 when not ACK-on-read.
- outstanding_o: +1 on accept, -1 on response; simultaneous accept and response leaves it unchanged.
- CYC_I low mid-operation (abort):
  - Pipeline valid bits and burst state cleared next edge; no further terminations emitted; outstanding_o goes to 0.
  - Already-committed writes persist.
- STB_I without CYC_I is ignored.
- Async reset mid-burst returns everything to reset values immediately.

Decomposition:
- Shared package/defines (NIC-defines): CTI codes (CTI_CLASSIC=000, CTI_INCR=010, CTI_END=111), response-class encoding (RSP_NONE/ACK/RTY/ERR), grant FSM state encoding.
- One natural sub-module: wb_rsp_delay_line (parametrised ACK_LATENCY shift register carrying valid/class/data with synchronous flush).

Test Plan:
- Single write then read: write 0xDEADBEEF to 0x10 with SEL=1111, then read 0x10 -> ACK at accept+2 each; read DAT_O=0xDEADBEEF.
- 6-beat incrementing burst, addresses 0x00..0x14, last beat CTI=111, ACK_LATENCY=2, MAX_OUTSTANDING=4 -> no stall, 6 ACKs back-to-back; outstanding_o peaks at 2.
- Burst address skip: third beat at 0x0C instead of 0x08 -> ERR_O on that beat only; the others ACK and data is not written.
- Limits: ACK_LATENCY=4, MAX_OUTSTANDING=2 -> STALL_O high when 2 are in flight; the third request is accepted on the cycle the first response fires.
- Injection and range: inject_rty_i on beat 2 -> RTY_O with no memory write; address 0x1000 with MEM_AW=6 -> ERR_O. Separately, STALL_PERIOD=3 -> exactly 1 stall after every 3 accepts.
- Abort: CYC_I dropped with 2 outstanding -> no terminations afterwards; gnt_wb_o low 1 cycle then high again GNT_DELAY cycles later. Async reset asserted mid-burst -> all outputs 0 at once.
